pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter with conditional branch, absolute jump and a small LIFO
// return stack for call/return. Overflow and underflow flags are sticky.
module pc_unit #(
   parameter int WIDTH    = 8,
   parameter int OFF_W    = 5,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         sJump,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         sBranch,
   input  logic                         zero,
   input  logic                         comp,
   input  logic [2:0]                   inst,
   input  logic [OFF_W-1:0]             offset,
   input  logic [WIDTH-1:0]             target,
   output logic [WIDTH-1:0]             pc,
   output logic [1:0]                   sel,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         ovf,
   output logic                         unf
);
   localparam int DW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WIDTH-1:0] PC0  = WIDTH'(RESET_PC);
   localparam logic [DW-1:0]    FULL = DW'(DEPTH);

   logic [WIDTH-1:0] stk [DEPTH];
   logic [WIDTH-1:0] seq, pc_nx, off_x, top;
   logic [AW-1:0]    top_i;
   logic             taken, empty, full, push, pop, ovf_set, unf_set;

   assign off_x = {{(WIDTH-OFF_W){offset[OFF_W-1]}}, offset};
   assign top_i = AW'(depth - 1'b1);
   assign top   = stk[top_i];

   always_comb begin
      taken   = sBranch & ((zero & (inst == 3'b100)) | (comp & (inst == 3'b110)));
      empty   = (depth == '0);
      full    = (depth == FULL);
      seq     = pc + 1'b1;
      sel     = 2'b00;
      pc_nx   = seq;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      // ret outranks jump, so a simultaneous call never pushes
      if (ret) begin
         sel     = 2'b11;
         pop     = !empty;
         unf_set = empty;
         pc_nx   = empty ? seq : top;
      end else if (sJump) begin
         sel     = 2'b10;
         pc_nx   = target;
         push    = call & !full;
         ovf_set = call & full;
      end else if (taken) begin
         sel     = 2'b01;
         pc_nx   = pc + off_x;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= PC0;
         depth <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (en) begin
         pc <= pc_nx;
         if (push)
            depth <= depth + 1'b1;
         else if (pop)
            depth <= depth - 1'b1;
         ovf <= ovf | ovf_set;
         unf <= unf | unf_set;
      end
   end

   // stack storage carries no reset; only entries below depth are meaningful
   always_ff @(posedge clk) begin
      if (en && push && !rst)
         stk[depth[AW-1:0]] <= seq;
   end
endmodule
